// File: rtl/sccb_responder.sv
// SCCB/I2C target: oversampled scl/sda, 3-phase write and 2-phase read,
// 256 x 8 register file with a host preload port and a bus-write strobe.
module sccb_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h21
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  inout  wire         sda,
  input  logic        cfg_we,
  input  logic [7:0]  cfg_addr,
  input  logic [7:0]  cfg_data,
  output logic        wr_stb,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic [15:0] debug_out
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV,
    S_DEV_ACK,
    S_SUB,
    S_SUB_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_IGNORE
  } state_t;

  state_t      state;
  logic [2:0]  scl_sr;
  logic [2:0]  sda_sr;
  logic [7:0]  shift;
  logic [7:0]  subaddr;
  logic [3:0]  bitcnt;
  logic        oe;
  logic        rd_mode;
  logic [7:0]  rf [256];

  logic        scl_s;
  logic        scl_p;
  logic        sda_s;
  logic        sda_p;
  logic        scl_rise;
  logic        scl_fall;
  logic        start_c;
  logic        stop_c;
  logic        last_bit;
  logic        bus_we;
  logic [7:0]  nbyte;
  logic [7:0]  rd_byte;
  logic [7:0]  rd_next;

  assign sda = oe ? 1'b0 : 1'bz;

  assign scl_s    = scl_sr[1];
  assign scl_p    = scl_sr[2];
  assign sda_s    = sda_sr[1];
  assign sda_p    = sda_sr[2];
  assign scl_rise = scl_s & ~scl_p;
  assign scl_fall = ~scl_s & scl_p;
  // Both synced scl samples high so an edge racing scl is never misread.
  assign start_c  = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_c   = scl_s & scl_p & ~sda_p & sda_s;
  assign last_bit = (bitcnt == 4'd7);
  assign nbyte    = {shift[6:0], sda_s};
  assign rd_byte  = rf[subaddr];
  assign rd_next  = rf[subaddr + 8'd1];

  assign bus_we = !rst && (state == S_WDATA) && scl_rise
                  && last_bit && !start_c && !stop_c;

  assign debug_out = {state, bitcnt, subaddr};

  // Two-flop synchronizers followed by the previous-value register.
  always_ff @(posedge clk) begin
    scl_sr <= {scl_sr[1:0], scl};
    sda_sr <= {sda_sr[1:0], sda};
  end

  // Register file: host preload, then bus write so the bus wins a collision.
  always_ff @(posedge clk) begin
    if (cfg_we) rf[cfg_addr] <= cfg_data;
    if (bus_we) rf[subaddr] <= nbyte;
  end

  // Protocol FSM with registered sda enable and write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      oe      <= 1'b0;
      shift   <= 8'h00;
      subaddr <= 8'h00;
      bitcnt  <= 4'd0;
      rd_mode <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= 8'h00;
      wr_data <= 8'h00;
    end else begin
      wr_stb <= 1'b0;
      if (start_c) begin
        state  <= S_DEV;
        bitcnt <= 4'd0;
        oe     <= 1'b0;
      end else if (stop_c) begin
        state  <= S_IDLE;
        bitcnt <= 4'd0;
        oe     <= 1'b0;
      end else begin
        unique case (state)
          S_DEV: if (scl_rise) begin
            shift  <= nbyte;
            bitcnt <= bitcnt + 4'd1;
            if (last_bit) begin
              bitcnt  <= 4'd0;
              rd_mode <= nbyte[0];
              state   <= (nbyte[7:1] == DEV_ADDR) ? S_DEV_ACK : S_IGNORE;
            end
          end
          S_SUB: if (scl_rise) begin
            shift  <= nbyte;
            bitcnt <= bitcnt + 4'd1;
            if (last_bit) begin
              bitcnt  <= 4'd0;
              subaddr <= nbyte;
              state   <= S_SUB_ACK;
            end
          end
          S_WDATA: if (scl_rise) begin
            shift  <= nbyte;
            bitcnt <= bitcnt + 4'd1;
            if (last_bit) begin
              bitcnt  <= 4'd0;
              wr_stb  <= 1'b1;
              wr_addr <= subaddr;
              wr_data <= nbyte;
              subaddr <= subaddr + 8'd1;
              state   <= S_WDATA_ACK;
            end
          end
          S_DEV_ACK: if (scl_fall) begin
            if (!oe) begin
              oe <= 1'b1;
              if (rd_mode) shift <= rd_byte;
            end else if (rd_mode) begin
              oe     <= ~shift[7];
              shift  <= {shift[6:0], 1'b0};
              bitcnt <= 4'd1;
              state  <= S_RDATA;
            end else begin
              oe    <= 1'b0;
              state <= S_SUB;
            end
          end
          S_SUB_ACK, S_WDATA_ACK: if (scl_fall) begin
            if (!oe) begin
              oe <= 1'b1;
            end else begin
              oe    <= 1'b0;
              state <= S_WDATA;
            end
          end
          S_RDATA: if (scl_fall) begin
            if (bitcnt == 4'd8) begin
              oe     <= 1'b0;
              bitcnt <= 4'd0;
              state  <= S_RDATA_ACK;
            end else begin
              oe     <= ~shift[7];
              shift  <= {shift[6:0], 1'b0};
              bitcnt <= bitcnt + 4'd1;
            end
          end
          S_RDATA_ACK: if (scl_rise) begin
            if (!sda_s) begin
              subaddr <= subaddr + 8'd1;
              shift   <= rd_next;
              state   <= S_RDATA;
            end else begin
              state <= S_IGNORE;
            end
          end
          S_IDLE, S_IGNORE: oe <= 1'b0;
          default: begin
            state <= S_IDLE;
            oe    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_responder.sv
// Bench for sccb_responder: directed test-plan steps plus random
// write/read transactions against a register-array model.
module tb_sccb_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        m_oe = 1'b0;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_addr = 8'h00;
  logic [7:0]  cfg_data = 8'h00;
  logic        wr_stb;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [15:0] debug_out;
  wire         sda;

  pullup (sda);
  assign sda = m_oe ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  sccb_responder #(.DEV_ADDR(7'h21)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .debug_out(debug_out)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  mrf [256];
  logic [7:0]  msub = 8'h00;
  logic [15:0] stb_q [$];
  logic [15:0] exp_q [$];
  bit          dut_low = 1'b0;

  always @(negedge clk) begin
    if (wr_stb) stb_q.push_back({wr_addr, wr_data});
    if (sda === 1'b0 && !m_oe) dut_low = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic [7:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick(1);
    cfg_we = 1'b0;
    mrf[a] = d;
  endtask

  task automatic bus_start();
    tick(3); m_oe = 1'b0; tick(4);
    scl = 1'b1; tick(8);
    m_oe = 1'b1; tick(8);
    scl = 1'b0;
  endtask

  task automatic bus_stop();
    tick(4); m_oe = 1'b1; tick(4);
    scl = 1'b1; tick(8);
    m_oe = 1'b0; tick(8);
  endtask

  task automatic send_bit(input logic b);
    tick(4); m_oe = ~b; tick(4);
    scl = 1'b1; tick(8);
    scl = 1'b0;
  endtask

  task automatic get_bit(output logic b);
    tick(4); m_oe = 1'b0; tick(4);
    scl = 1'b1; tick(4);
    b = (sda === 1'b0) ? 1'b0 : 1'b1;
    tick(4);
    scl = 1'b0;
  endtask

  // collide: host preload 0x1C=0x00 in the cycle the last bit is sampled
  task automatic send_byte(input logic [7:0] b, input bit collide,
                           output logic ack);
    for (int i = 7; i >= 0; i--) begin
      tick(4); m_oe = ~b[i]; tick(4);
      scl = 1'b1;
      if (collide && i == 0) begin
        tick(2);
        cfg_we = 1'b1; cfg_addr = 8'h1C; cfg_data = 8'h00;
        tick(1);
        cfg_we = 1'b0;
        tick(5);
      end else begin
        tick(8);
      end
      scl = 1'b0;
    end
    get_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      get_bit(b);
      d = {d[6:0], b};
    end
    send_bit(nack);
  endtask

  task automatic wr_txn(input logic [7:0] a, input int n,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input bit collide);
    logic       ack;
    logic [7:0] d [3];
    logic [7:0] ad;
    d = '{d0, d1, d2};
    stb_q.delete();
    exp_q.delete();
    ad = a;
    bus_start();
    send_byte(8'h42, 1'b0, ack); chk("wr_dev_ack", ack, 0);
    send_byte(a, 1'b0, ack);     chk("wr_sub_ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      send_byte(d[i], collide && i == 0, ack);
      chk("wr_data_ack", ack, 0);
      mrf[ad] = d[i];
      exp_q.push_back({ad, d[i]});
      ad = ad + 8'd1;
    end
    bus_stop();
    msub = ad;
    chk("wr_stb_count", stb_q.size(), exp_q.size());
    for (int i = 0; i < n && i < stb_q.size(); i++)
      chk("wr_stb_addr_data", stb_q[i], exp_q[i]);
  endtask

  task automatic rd_txn(input bit set_a, input logic [7:0] a,
                        input int n);
    logic       ack;
    logic [7:0] d;
    if (set_a) begin
      bus_start();
      send_byte(8'h42, 1'b0, ack); chk("rd_wdev_ack", ack, 0);
      send_byte(a, 1'b0, ack);     chk("rd_sub_ack", ack, 0);
      bus_stop();
      msub = a;
    end
    bus_start();
    send_byte(8'h43, 1'b0, ack); chk("rd_dev_ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, d);
      chk("rd_data", d, mrf[msub]);
      if (i != n - 1) msub = msub + 8'd1;
    end
    tick(2);
    chk("rd_release", sda, 1);
    bus_stop();
  endtask

  initial begin
    logic       ack;
    logic       b;
    int         op;
    logic [7:0] ra;

    tick(4);
    chk("rst_debug", debug_out, 16'h0000);
    chk("rst_stb", wr_stb, 0);
    chk("rst_sda", sda, 1);
    chk("rst_wr_addr", wr_addr, 8'h00);
    chk("rst_wr_data", wr_data, 8'h00);
    rst = 1'b0;
    tick(4);

    for (int i = 0; i < 256; i++)
      cfg_wr(i[7:0], 8'($urandom));

    // 3-phase write
    wr_txn(8'h1C, 1, 8'hA5, 8'h00, 8'h00, 1'b0);
    rd_txn(1'b1, 8'h1C, 1);

    // 2-phase read of a preloaded register
    cfg_wr(8'h1D, 8'h7F);
    rd_txn(1'b1, 8'h1D, 1);

    // wrong device ID
    stb_q.delete();
    dut_low = 1'b0;
    bus_start();
    send_byte(8'h44, 1'b0, ack); chk("bad_id_nack0", ack, 1);
    send_byte(8'h00, 1'b0, ack); chk("bad_id_nack1", ack, 1);
    send_byte(8'h11, 1'b0, ack); chk("bad_id_nack2", ack, 1);
    bus_stop();
    chk("bad_id_no_drive", dut_low, 0);
    chk("bad_id_no_stb", stb_q.size(), 0);

    // burst with subaddr wrap
    wr_txn(8'hFF, 2, 8'h01, 8'h02, 8'h00, 1'b0);
    rd_txn(1'b1, 8'hFF, 2);

    // host preload colliding with a bus write
    cfg_wr(8'h1C, 8'h33);
    wr_txn(8'h1C, 1, 8'hA5, 8'h00, 8'h00, 1'b1);
    rd_txn(1'b1, 8'h1C, 1);

    // repeated start mid-SUB, then reset during RDATA
    cfg_wr(8'h40, 8'h3C);
    rd_txn(1'b1, 8'h40, 1);
    bus_start();
    send_byte(8'h42, 1'b0, ack); chk("rs_dev_ack", ack, 0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    bus_start();
    send_byte(8'h43, 1'b0, ack); chk("rs_rd_ack", ack, 0);
    tick(5);
    chk("rs_msb_driven", sda, 0);
    rst = 1'b1;
    tick(1);
    chk("rs_rst_release", sda, 1);
    chk("rs_rst_debug", debug_out, 16'h0000);
    rst = 1'b0;
    dut_low = 1'b0;
    for (int i = 0; i < 3; i++) get_bit(b);
    bus_stop();
    chk("rs_quiet_after_rst", dut_low, 0);
    msub = 8'h00;
    rd_txn(1'b0, 8'h00, 1);
    rd_txn(1'b1, 8'h40, 1);
    rd_txn(1'b1, 8'h1C, 1);

    // random transactions against the model
    for (int t = 0; t < 24; t++) begin
      op = $urandom_range(0, 3);
      ra = 8'($urandom);
      case (op)
        0: begin
          cfg_wr(ra, 8'($urandom));
          cfg_wr(ra + 8'd1, 8'($urandom));
        end
        1: wr_txn(ra, $urandom_range(1, 3), 8'($urandom),
                  8'($urandom), 8'($urandom), 1'b0);
        2: rd_txn(1'b1, ra, $urandom_range(1, 3));
        default: rd_txn(1'b0, 8'h00, $urandom_range(1, 3));
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
